// File: rtl/core_add_pipe.sv
// Mantissa add/subtract and renormalisation core for the posit adder path.
// Operand arithmetic and normalisation happen ahead of a STAGES-deep valid/ready pipeline.
module core_add_pipe #(
    parameter int TE_BITS   = 12,
    parameter int MANT_SIZE = 14,
    parameter int STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [MANT_SIZE-1:0]      a_i,
    input  logic [MANT_SIZE-1:0]      b_i,
    input  logic                      sub_i,
    input  logic signed [TE_BITS-1:0] te_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MANT_SIZE:0]        mant_o,
    output logic signed [TE_BITS-1:0] te_o,
    output logic                      neg_o,
    output logic                      zero_o,
    output logic                      frac_trunc_o,
    output logic                      te_sat_o
);

    localparam int W    = MANT_SIZE + 1;
    localparam int LZ_W = $clog2(W);

    typedef struct packed {
        logic [W-1:0]       mant;
        logic [TE_BITS-1:0] te;
        logic               neg;
        logic               zero;
        logic               frac_trunc;
        logic               te_sat;
    } res_t;

    // Highest set bit wins, so the count is taken from the MSB side.
    function automatic logic [LZ_W-1:0] lead_zeros(input logic [W-2:0] v);
        logic [LZ_W-1:0] n;
        n = '0;
        for (int i = 0; i < W - 1; i++) begin
            if (v[i]) n = LZ_W'(W - 2 - i);
        end
        return n;
    endfunction

    // Returns {sat, te}: a mismatch of the top two bits means the value left the TE_BITS range.
    function automatic logic [TE_BITS:0] sat_te(input logic signed [TE_BITS:0] t);
        if (t[TE_BITS] != t[TE_BITS-1])
            return {1'b1, t[TE_BITS], {(TE_BITS-1){~t[TE_BITS]}}};
        return {1'b0, t[TE_BITS-1:0]};
    endfunction

    logic [W-1:0]              a_ext;
    logic [W-1:0]              b_ext;
    logic [W-1:0]              sum_c;
    logic                      neg_c;
    logic [LZ_W-1:0]           lz_c;
    logic signed [TE_BITS:0]   te_ext;
    logic signed [TE_BITS:0]   te_adj;
    logic [TE_BITS:0]          te_sat_c;
    res_t                      res_c;

    always_comb begin
        a_ext    = {1'b0, a_i};
        b_ext    = {1'b0, b_i};
        neg_c    = sub_i & (a_i < b_i);
        if (!sub_i)
            sum_c = a_ext + b_ext;
        else if (neg_c)
            sum_c = b_ext - a_ext;
        else
            sum_c = a_ext - b_ext;

        te_ext   = {te_i[TE_BITS-1], te_i};
        lz_c     = lead_zeros(sum_c[W-2:0]);
        res_c    = '0;
        res_c.neg = neg_c;
        te_adj   = te_ext;

        if (sum_c[W-1]) begin
            res_c.mant       = sum_c >> 1;
            res_c.frac_trunc = sum_c[0];
            te_adj           = te_ext + $signed((TE_BITS+1)'(1));
        end else begin
            res_c.mant = sum_c << lz_c;
            te_adj     = te_ext - $signed((TE_BITS+1)'(lz_c));
        end

        te_sat_c = sat_te(te_adj);
        if (sum_c == '0) begin
            res_c.mant = '0;
            res_c.zero = 1'b1;
        end else begin
            res_c.te     = te_sat_c[TE_BITS-1:0];
            res_c.te_sat = te_sat_c[TE_BITS];
        end

        if (!in_valid_i) res_c = '0;
    end

    logic advance;
    res_t res_p0;
    logic vld_p0;
    res_t res_out;
    logic vld_out;

    assign advance = ~vld_out | out_ready_i;

    // Stage p0: capture the computed result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p0 <= 1'b0;
            res_p0 <= '0;
        end else if (advance) begin
            vld_p0 <= in_valid_i;
            res_p0 <= res_c;
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            assign vld_out = vld_p0;
            assign res_out = res_p0;
        end else begin : g_multi
            res_t res_p1;
            logic vld_p1;

            // Stage p1.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_p1 <= 1'b0;
                    res_p1 <= '0;
                end else if (advance) begin
                    vld_p1 <= vld_p0;
                    res_p1 <= res_p0;
                end
            end

            if (STAGES == 2) begin : g_two
                assign vld_out = vld_p1;
                assign res_out = res_p1;
            end else begin : g_three
                res_t res_p2;
                logic vld_p2;

                // Stage p2.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        vld_p2 <= 1'b0;
                        res_p2 <= '0;
                    end else if (advance) begin
                        vld_p2 <= vld_p1;
                        res_p2 <= res_p1;
                    end
                end

                assign vld_out = vld_p2;
                assign res_out = res_p2;
            end
        end
    endgenerate

    assign in_ready_o   = advance;
    assign out_valid_o  = vld_out;
    assign mant_o       = res_out.mant;
    assign te_o         = res_out.te;
    assign neg_o        = res_out.neg;
    assign zero_o       = res_out.zero;
    assign frac_trunc_o = res_out.frac_trunc;
    assign te_sat_o     = res_out.te_sat;

endmodule

// File: tb/tb_core_add_pipe.sv
// Bench for core_add_pipe: three instances (STAGES 1..3) with MANT_SIZE=8, TE_BITS=8,
// directed corner beats plus a randomized stream scored against an arithmetic model.
module tb_core_add_pipe;

    localparam int MS  = 8;
    localparam int TEB = 8;
    localparam int W   = MS + 1;
    localparam int TE_MAX = (1 << (TEB - 1)) - 1;
    localparam int TE_MIN = -(1 << (TEB - 1));

    typedef struct {
        int mant;
        int te;
        bit neg;
        bit zero;
        bit trunc;
        bit sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [MS-1:0] a_in = '0;
    logic [MS-1:0] b_in = '0;
    logic          sub_in = 1'b0;
    logic [TEB-1:0] te_in = '0;

    logic          in_valid  [1:3];
    logic          in_ready  [1:3];
    logic          out_valid [1:3];
    logic          out_ready [1:3];
    logic [W-1:0]  mant      [1:3];
    logic [TEB-1:0] te_out   [1:3];
    logic          neg       [1:3];
    logic          zero      [1:3];
    logic          trunc     [1:3];
    logic          sat       [1:3];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   emits   = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        core_add_pipe #(.TE_BITS(TEB), .MANT_SIZE(MS), .STAGES(g)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .a_i         (a_in),
            .b_i         (b_in),
            .sub_i       (sub_in),
            .te_i        (te_in),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .mant_o      (mant[g]),
            .te_o        (te_out[g]),
            .neg_o       (neg[g]),
            .zero_o      (zero[g]),
            .frac_trunc_o(trunc[g]),
            .te_sat_o    (sat[g])
        );
    end

    task automatic check(input string tag, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference: exact sum/difference, then normalise the magnitude into [2^(W-2), 2^(W-1)).
    function automatic exp_t model(input int a, input int b, input bit s, input int te);
        exp_t e;
        int   sum;
        int   t;
        e = '{default: 0};
        if (!s) sum = a + b;
        else if (a >= b) sum = a - b;
        else begin
            sum   = b - a;
            e.neg = 1'b1;
        end
        if (sum == 0) begin
            e.zero = 1'b1;
            return e;
        end
        t = te;
        if (sum >= (1 << (W - 1))) begin
            e.mant  = sum / 2;
            e.trunc = sum[0];
            t       = te + 1;
        end else begin
            e.mant = sum;
            while (e.mant < (1 << (W - 2))) begin
                e.mant = e.mant * 2;
                t      = t - 1;
            end
        end
        if (t > TE_MAX) begin
            t     = TE_MAX;
            e.sat = 1'b1;
        end else if (t < TE_MIN) begin
            t     = TE_MIN;
            e.sat = 1'b1;
        end
        e.te = t;
        return e;
    endfunction

    task automatic check_fields(input string tag, input int g, input exp_t e);
        check({tag, "_mant"},  int'(mant[g]), e.mant);
        check({tag, "_te"},    int'($signed(te_out[g])), e.te);
        check({tag, "_neg"},   int'(neg[g]), int'(e.neg));
        check({tag, "_zero"},  int'(zero[g]), int'(e.zero));
        check({tag, "_trunc"}, int'(trunc[g]), int'(e.trunc));
        check({tag, "_sat"},   int'(sat[g]), int'(e.sat));
    endtask

    // Scoreboard on the STAGES=2 instance: emit pops before accept pushes.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid[2] && out_ready[2]) begin
                emits++;
                check("sb_pending", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check_fields("sb", 2, mon_e);
                end
            end
            if (in_valid[2] && in_ready[2])
                q.push_back(model(int'(a_in), int'(b_in), sub_in, int'($signed(te_in))));
        end
    end

    task automatic set_inputs(input int a, input int b, input bit s, input int t);
        a_in   = MS'(a);
        b_in   = MS'(b);
        sub_in = s;
        te_in  = TEB'(t);
    endtask

    // One beat into all three instances from an empty pipeline, outputs always ready.
    task automatic directed(input string tag, input int a, input int b, input bit s, input int t);
        exp_t e;
        int   lat [1:3];
        e = model(a, b, s, t);
        set_inputs(a, b, s, t);
        for (int g = 1; g <= 3; g++) begin
            in_valid[g] = 1'b1;
            lat[g]      = 0;
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)
                for (int g = 1; g <= 3; g++) in_valid[g] = 1'b0;
            for (int g = 1; g <= 3; g++) begin
                if (lat[g] == 0 && out_valid[g]) begin
                    lat[g] = k;
                    check_fields($sformatf("%s_s%0d", tag, g), g, e);
                end
            end
        end
        for (int g = 1; g <= 3; g++)
            check($sformatf("%s_s%0d_lat", tag, g), lat[g], g);
    endtask

    task automatic drive2(input int a, input int b, input bit s, input int t);
        int w;
        w = 0;
        set_inputs(a, b, s, t);
        in_valid[2] = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready[2]) break;
            w++;
            if (w > 100) begin
                check("drive_timeout", w, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_m();
        case ($urandom % 6)
            0: return 0;
            1: return 1;
            2: return 1 << (MS - 1);
            3: return (1 << MS) - 1;
            default: return int'($urandom % (1 << MS));
        endcase
    endfunction

    function automatic int pick_te();
        case ($urandom % 5)
            0: return TE_MAX;
            1: return TE_MIN;
            2: return TE_MIN + 3;
            3: return 0;
            default: return int'($urandom % (1 << TEB)) + TE_MIN;
        endcase
    endfunction

    initial begin
        exp_t e0;
        int   base;
        bit   done;
        for (int g = 1; g <= 3; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 1; g <= 3; g++) begin
            check($sformatf("rst_s%0d_out_valid", g), int'(out_valid[g]), 0);
            check($sformatf("rst_s%0d_in_ready", g), int'(in_ready[g]), 1);
        end
        check("rst_mant", int'(mant[2]), 0);
        check("rst_te", int'(te_out[2]), 0);
        check("rst_flags", int'({neg[2], zero[2], trunc[2], sat[2]}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("t1_add_carry", 'hC0, 'h80, 1'b0, 3);
        directed("t2_add_trunc", 'hC1, 'h80, 1'b0, 3);
        directed("t3_sub_lz",    'h90, 'h88, 1'b1, 5);
        directed("t4_sub_zero",  'h55, 'h55, 1'b1, 9);
        directed("t4_sub_neg",   'h10, 'h20, 1'b1, 0);
        directed("t5_sat_hi",    'hFF, 'hFF, 1'b0, 127);
        directed("t5_sat_lo",    'h02, 'h01, 1'b1, -125);

        // Back-pressure from the first beat: two beats fill the pipe, the third waits.
        base = emits;
        e0 = model('h31, 'h07, 1'b0, 10);
        out_ready[2] = 1'b0;
        drive2('h31, 'h07, 1'b0, 10);
        drive2('hA0, 'h0F, 1'b1, -4);
        set_inputs('h03, 'hF0, 1'b1, 20);
        in_valid[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready[2]), 0);
            check("stall_out_valid", int'(out_valid[2]), 1);
            check("stall_hold_mant", int'(mant[2]), e0.mant);
            check("stall_hold_te", int'($signed(te_out[2])), e0.te);
        end
        @(posedge clk);
        #1;
        out_ready[2] = 1'b1;
        drive2('h03, 'hF0, 1'b1, 20);
        drive2('hFF, 'h01, 1'b0, -7);
        in_valid[2] = 1'b0;
        for (int k = 0; k < 20 && (emits - base) < 4; k++) @(negedge clk);
        check("stall_count", emits - base, 4);

        // Reset with two beats in flight: nothing may surface afterwards.
        drive2('h40, 'h40, 1'b0, 1);
        drive2('h21, 'h03, 1'b1, 2);
        in_valid[2] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid[2]), 0);
        check("midrst_mant", int'(mant[2]), 0);
        check("midrst_in_ready", int'(in_ready[2]), 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_no_stale", int'(out_valid[2]), 0);
        end
        @(posedge clk);
        #1;

        // Random stream with random bubbles and back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    drive2(pick_m(), pick_m(), 1'($urandom % 2), pick_te());
                    if ($urandom % 4 == 0) begin
                        in_valid[2] = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid[2] = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready[2] = ($urandom % 4) != 0;
                end
                out_ready[2] = 1'b1;
            end
        join
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        check("sb_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
